tt_tinycore_gen: RTL and testbench
==================================

Name: tt_tinycore_gen

Overview:
Parametrised accumulator micro-core, successor to the fixed 8-bit, 16-word tiny core. Adds configurable data and address widths, a writable instruction memory loaded through a program port, zero/carry flags, conditional branches on both, logic ops, an input opcode, HALT, and an explicit start/busy/halted control handshake. Sits behind the tile's dedicated I/O wrapper. The wrapper maps ui_in/uio_in to the program port and data input, and maps out_data/status to uo_out/uio_out.

Parameters:
DATA_W, 8, accumulator/ALU/output width (>=4)
ADDR_W, 5, PC and operand width; IMEM depth = 2**ADDR_W
INSTR_W, derived = 4 + ADDR_W, instruction word width (localparam, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  clock enable; low freezes all state, including IMEM writes
start  in  1  level-sampled; begins execution from pc=0 when in IDLE or HALT
prog_we  in  1  IMEM write strobe
prog_addr  in  ADDR_W  IMEM write address
prog_wdata  in  INSTR_W  IMEM write data {opcode[3:0], operand[ADDR_W-1:0]}
in_data  in  DATA_W  external operand for IN
out_data  out  DATA_W  last stored accumulator
out_valid  out  1  one-cycle pulse when out_data updates
busy  out  1  high in FETCH/EXEC
halted  out  1  high in HALT
pc_dbg  out  ADDR_W  current PC

Behaviour:
- Reset (async): state=IDLE, pc=0, acc=0, ir=0, Z=0, C=0, out_data=0, out_valid=0. IMEM is not reset; contents survive reset.
- All state updates are gated by ena. With ena low, out_valid is held low.
- FSM states: IDLE -> (start) FETCH -> EXEC -> FETCH ..., EXEC -> HALT on HLT; HALT -> (start) FETCH.
- Entering FETCH from IDLE/HALT clears pc, acc, Z and C.
- FETCH: ir <= imem[pc]. EXEC: execute ir and update pc. Every instruction costs exactly 2 enabled cycles.
- IMEM writes are accepted only in IDLE/HALT. prog_we while busy is ignored. If start and prog_we coincide, the write is performed and start is also taken.
- start while busy is ignored.
- imm = operand zero-extended (or truncated) to DATA_W. Default pc_next = pc+1 mod 2**ADDR_W; the PC wraps from the last word to 0.
- Opcodes:
  - 0 NOP
  - 1 LDI: acc=imm
  - 2 ADD: {C,acc}=acc+imm
  - 3 SUB: acc=acc-imm, C=borrow (acc<imm)
  - 4 AND, 5 OR, 6 XOR with imm: C=0
  - 7 JMP: pc=operand
  - 8 BEQ: pc=operand if Z
  - 9 BNE: pc=operand if !Z
  - A BCS: pc=operand if C
  - B STR: out_data=acc, out_valid=1 for that cycle
  - C IN: acc=in_data
  - D HLT: pc holds, next state HALT
  - E/F: treated as NOP
- Z = (new acc==0) after LDI/ADD/SUB/AND/OR/XOR/IN. Other opcodes leave Z and C unchanged.
- Branch tests use the flags as they stand at the start of EXEC.
- Reset mid-operation aborts immediately. No partial output pulse appears after reset.

Test Plan:
- Load [LDI 1, ADD 2, STR, HLT], start pulse at cycle 0 -> busy in cycles 1-8, out_data=3 with a single out_valid pulse at cycle 6, halted=1 from cycle 9, pc_dbg=3.
- DATA_W=8, [LDI 0, SUB 1, BCS 4, NOP, STR, HLT] -> out_data=0xFF, C=1, NOP at address 3 never executed (pc trace 0,1,2,4,5).
- Countdown [LDI 3, SUB 1, STR, BNE 1, HLT] -> out_valid pulses with 2,1,0 in order, then halted.
- Fill IMEM with NOP except word 31 = NOP and word 0 overwritten via JMP target test -> pc wraps 31->0; prog_we during busy leaves IMEM unchanged (read back via execution).
- Hold ena low 5 cycles mid-program -> pc/acc/state/out_data frozen, out_valid=0, execution resumes identically.
- Assert rst_n low during EXEC of STR -> outputs return to reset values asynchronously, no out_valid. Restart reruns the retained program with identical results.

Source files
------------

// File: rtl/tt_tinycore_gen.sv
// Parametrised accumulator micro-core with writable IMEM and start/busy/halt control.
// Ports: clk/rst_n/ena, start, prog_we/addr/wdata, in_data, out_data/out_valid, busy, halted, pc_dbg.
module tt_tinycore_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_wdata,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int INSTR_W = 4 + ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_BNE = 4'h9;
  localparam logic [3:0] OP_BCS = 4'hA;
  localparam logic [3:0] OP_STR = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [INSTR_W-1:0]  imem [DEPTH];

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [ADDR_W-1:0]   pc_inc;
  logic                idle_like;
  logic                str_hit;
  logic                upd_z;

  assign opcode    = ir_q[INSTR_W-1:ADDR_W];
  assign operand   = ir_q[ADDR_W-1:0];
  assign imm       = DATA_W'(operand);
  assign sum       = {1'b0, acc_q} + {1'b0, imm};
  // MSB of the widened difference is the borrow (acc < imm)
  assign diff      = {1'b0, acc_q} - {1'b0, imm};
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (ena && prog_we && idle_like) begin
      imem[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    ir_d       = ir_q;
    z_d        = z_q;
    c_d        = c_q;
    out_data_d = out_data_q;
    str_hit    = 1'b0;
    upd_z      = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          z_d     = 1'b0;
          c_d     = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_LDI: begin
            acc_d = imm;
            upd_z = 1'b1;
          end
          OP_ADD: begin
            acc_d = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
            upd_z = 1'b1;
          end
          OP_SUB: begin
            acc_d = diff[DATA_W-1:0];
            c_d   = diff[DATA_W];
            upd_z = 1'b1;
          end
          OP_AND: begin
            acc_d = acc_q & imm;
            c_d   = 1'b0;
            upd_z = 1'b1;
          end
          OP_OR: begin
            acc_d = acc_q | imm;
            c_d   = 1'b0;
            upd_z = 1'b1;
          end
          OP_XOR: begin
            acc_d = acc_q ^ imm;
            c_d   = 1'b0;
            upd_z = 1'b1;
          end
          OP_JMP: pc_d = operand;
          OP_BEQ: if (z_q) pc_d = operand;
          OP_BNE: if (!z_q) pc_d = operand;
          OP_BCS: if (c_q) pc_d = operand;
          OP_STR: begin
            out_data_d = acc_q;
            str_hit    = 1'b1;
          end
          OP_IN: begin
            acc_d = in_data;
            upd_z = 1'b1;
          end
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
        if (upd_z) z_d = (acc_d == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      ir_q       <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      out_data_q <= '0;
    end else if (ena) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      ir_q       <= ir_d;
      z_q        <= z_d;
      c_q        <= c_d;
      out_data_q <= out_data_d;
    end
  end

  // The store pulse is shown during the EXEC cycle of STR, with the
  // stored value presented alongside it.
  assign out_valid = str_hit && ena;
  assign out_data  = out_valid ? acc_q : out_data_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_tt_tinycore_gen.sv
// Directed self-checking bench for tt_tinycore_gen (DATA_W=8, ADDR_W=5).
// Loads small programs, runs them and checks outputs against hand-computed values.
module tb_tt_tinycore_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [8:0] prog_wdata;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       halted;
  logic [4:0] pc_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] outs[$];
  logic [4:0] pcs[$];
  logic [8:0] prog[$];

  always #5 clk = ~clk;

  tt_tinycore_gen #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .halted(halted), .pc_dbg(pc_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] w(input logic [3:0] op, input logic [4:0] opd);
    return {op, opd};
  endfunction

  task automatic load_all();
    for (int i = 0; i < prog.size(); i++) begin
      prog_we    = 1'b1;
      prog_addr  = 5'(i);
      prog_wdata = prog[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs from the first FETCH until HALT; logs stores and fetched PCs.
  task automatic run(input int max, input bit poke);
    int n;
    n = 0;
    outs.delete();
    pcs.delete();
    if (poke) begin
      prog_we    = 1'b1;
      prog_addr  = 5'd3;
      prog_wdata = 9'h000;
    end
    while (!halted && n < max) begin
      if (out_valid) outs.push_back(out_data);
      if (n % 2 == 0) pcs.push_back(pc_dbg);
      n++;
      tick();
    end
    prog_we = 1'b0;
    check("halt_reached", halted, 1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; in_data = 8'h00;
    #12;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_out", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_pc", pc_dbg, 0);
    rst_n = 1'b1;
    tick();

    // T1: LDI 1, ADD 2, STR, HLT; last write coincides with start
    prog = '{w(1, 1), w(2, 2), w(4'hB, 0)};
    load_all();
    prog_we = 1'b1; prog_addr = 5'd3; prog_wdata = w(4'hD, 0);
    start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("t1_busy_c%0d", c), busy, (c <= 8) ? 1 : 0);
      check($sformatf("t1_valid_c%0d", c), out_valid, (c == 6) ? 1 : 0);
      if (c == 6) check("t1_out_c6", out_data, 3);
      if (c < 9) tick();
    end
    check("t1_halted", halted, 1);
    check("t1_pc", pc_dbg, 3);
    check("t1_out_hold", out_data, 3);

    // T2: borrow sets C, BCS skips the NOP at 3
    prog = '{w(1, 0), w(3, 1), w(4'hA, 4), w(0, 0), w(4'hB, 0), w(4'hD, 0)};
    load_all();
    go();
    run(100, 0);
    check("t2_nout", outs.size(), 1);
    check("t2_out", outs[0], 8'hFF);
    check("t2_ntrace", pcs.size(), 5);
    check("t2_pc2", pcs[2], 2);
    check("t2_pc3", pcs[3], 4);
    check("t2_pc4", pcs[4], 5);

    // T3: countdown with BNE
    prog = '{w(1, 3), w(3, 1), w(4'hB, 0), w(9, 1), w(4'hD, 0)};
    load_all();
    go();
    run(200, 0);
    check("t3_nout", outs.size(), 3);
    check("t3_out0", outs[0], 2);
    check("t3_out1", outs[1], 1);
    check("t3_out2", outs[2], 0);
    check("t3_pc", pc_dbg, 4);

    // T4: ena held low during EXEC of the first STR
    go();
    for (int i = 0; i < 5; i++) tick();
    check("t4_pre_valid", out_valid, 1);
    ena = 1'b0;
    #1;
    check("t4_gate_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_pc_%0d", i), pc_dbg, 2);
      check($sformatf("t4_busy_%0d", i), busy, 1);
      check($sformatf("t4_valid_%0d", i), out_valid, 0);
      check($sformatf("t4_out_%0d", i), out_data, 0);
    end
    ena = 1'b1;
    #1;
    check("t4_resume_valid", out_valid, 1);
    check("t4_resume_out", out_data, 2);
    tick();
    run(200, 0);
    check("t4_nout", outs.size(), 2);
    check("t4_out0", outs[0], 1);
    check("t4_out1", outs[1], 0);
    check("t4_pc", pc_dbg, 4);

    // T5: async reset during EXEC of STR, then rerun retained program
    go();
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_out", out_data, 0);
    check("t5_pc", pc_dbg, 0);
    check("t5_halted", halted, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle_busy", busy, 0);
    go();
    run(200, 0);
    check("t5_nout", outs.size(), 3);
    check("t5_out0", outs[0], 2);
    check("t5_out1", outs[1], 1);
    check("t5_out2", outs[2], 0);

    // T6: PC wrap 31->0; writes to word 3 (HLT) while busy are ignored
    prog.delete();
    for (int i = 0; i < 32; i++) prog.push_back(w(0, 0));
    prog[0] = w(3, 1);
    prog[1] = w(4'hB, 0);
    prog[2] = w(4'hA, 31);
    prog[3] = w(4'hD, 0);
    load_all();
    go();
    run(200, 1);
    check("t6_nout", outs.size(), 2);
    check("t6_out0", outs[0], 8'hFF);
    check("t6_out1", outs[1], 8'hFE);
    check("t6_ntrace", pcs.size(), 8);
    check("t6_pc3", pcs[3], 31);
    check("t6_pc4", pcs[4], 0);
    check("t6_pc7", pcs[7], 3);

    // T7: IN, ADD carry, logic ops, BEQ on zero
    in_data = 8'hF0;
    prog = '{w(4'hC, 0), w(2, 31), w(4'hA, 4), w(4'hD, 0), w(4'hB, 0),
             w(4, 5'h0C), w(5, 5'h11), w(6, 5'h0F), w(4'hB, 0),
             w(6, 5'h12), w(8, 12), w(4'hD, 0), w(4'hB, 0), w(4'hD, 0)};
    load_all();
    go();
    run(300, 0);
    check("t7_nout", outs.size(), 3);
    check("t7_out0", outs[0], 8'h0F);
    check("t7_out1", outs[1], 8'h12);
    check("t7_out2", outs[2], 8'h00);
    check("t7_pc", pc_dbg, 13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
